// File: rtl/alu_exec_stage.sv
// Two-stage registered ALU execute unit with valid/ready handshake on both sides.
// Stage 1 captures operands and control; stage 2 registers the result and flags.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic             s1_valid;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctl_q;

  logic             s2_load;
  logic             accept;
  logic             retire;

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             sub_ovf;

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             ill_d;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  // SUB and SLT share the adder as A + ~B + 1, so Carry is the NOT-borrow.
  assign sub_mode = (ctl_q == OP_SUB) || (ctl_q == OP_SLT);
  assign b_eff    = sub_mode ? ~b_q : b_q;
  assign sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
  assign add_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (ctl_q)
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = add_ovf;
      end
      OP_SUB: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = sub_ovf;
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_SLT: begin
        // Signed less-than: sign of the difference corrected by overflow.
        res_d   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sub_ovf};
        carry_d = sum[WIDTH];
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      a_q      <= SrcA;
      b_q      <= SrcB;
      ctl_q    <= ALUControl;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      Result    <= res_d;
      Zero      <= (res_d == '0);
      Negative  <= res_d[WIDTH-1];
      Carry     <= carry_d;
      Overflow  <= ovf_d;
      Illegal   <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (retire && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic edges, back-pressure, streaming,
// async reset mid-flight and counter saturation on a CNT_W=3 twin.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [2:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Result;
  logic        Zero, Negative, Carry, Overflow, Illegal;
  logic [15:0] op_count;

  logic        in_ready_s, out_valid_s;
  logic [31:0] result_s;
  logic        zero_s, negative_s, carry_s, overflow_s, illegal_s;
  logic [2:0]  op_count_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .Illegal(Illegal), .op_count(op_count)
  );

  alu_exec_stage #(.WIDTH(32), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid_s), .out_ready(out_ready), .Result(result_s),
    .Zero(zero_s), .Negative(negative_s), .Carry(carry_s), .Overflow(overflow_s),
    .Illegal(illegal_s), .op_count(op_count_s)
  );

  // Flags packed as {Illegal, Overflow, Carry, Negative, Zero}.
  wire [4:0] flags = {Illegal, Overflow, Carry, Negative, Zero};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] model(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    longint      sv;
    logic [31:0] r;
    logic        cy, ov, il;
    r = '0; cy = 1'b0; ov = 1'b0; il = 1'b0;
    case (c)
      3'b000: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        sv = longint'($signed(a)) + longint'($signed(b));
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'b001: begin
        r  = a - b;
        cy = (a >= b);
        sv = longint'($signed(a)) - longint'($signed(b));
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: begin
        r  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        cy = (a >= b);
      end
      default: il = 1'b1;
    endcase
    return {il, ov, cy, r[31], (r == 32'd0), r};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [4:0] ef);
    in_valid = 1'b1; ALUControl = c; SrcA = a; SrcB = b;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, 64'(Result), 64'(er));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
  endtask

  logic [31:0] bp_exp [6];
  logic [31:0] tp_r [100];
  logic [4:0]  tp_f [100];
  logic [36:0] m;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_in, bp_out, tp_in, tp_out;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);

    // Directed vectors, out_ready held high
    do_op("add_5_7",   3'b000, 32'd5,          32'd7,          32'd12,         5'b00000);
    do_op("sub_3_3",   3'b001, 32'd3,          32'd3,          32'd0,          5'b00101);
    do_op("add_ovf",   3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  5'b01010);
    do_op("add_carry", 3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          5'b00101);
    do_op("sub_ovf",   3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  5'b01100);
    do_op("and",       3'b010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  5'b00000);
    do_op("or",        3'b011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  5'b00000);
    do_op("slt_true",  3'b101, 32'hFFFF_FFFB,  32'd3,          32'd1,          5'b00100);
    do_op("slt_false", 3'b101, 32'd3,          32'hFFFF_FFFB,  32'd0,          5'b00001);
    do_op("illegal",   3'b111, 32'd5,          32'd7,          32'd0,          5'b10001);
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("op_count_10", 64'(op_count), 64'd10);
    chk("sat_op_count_7", 64'(op_count_s), 64'd7);

    // Back-pressure: out_ready low for cycles 2..5
    for (int i = 0; i < 6; i++) bp_exp[i] = 32'h1111_1111 * i + 32'(i + 1);
    bp_in = 0; bp_out = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid   = (bp_in < 6);
      ALUControl = 3'b000;
      SrcA       = 32'h1111_1111 * bp_in;
      SrcB       = 32'(bp_in + 1);
      out_ready  = !(cyc >= 2 && cyc <= 5);
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_result", 64'(Result), 64'(bp_exp[0]));
      end
      if (out_valid && out_ready) begin
        chk("bp_order", 64'(Result), 64'(bp_exp[bp_out < 6 ? bp_out : 5]));
        bp_out++;
      end
      if (in_valid && in_ready) bp_in++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_out", 64'(bp_out), 64'd6);
    chk("bp_op_count", 64'(op_count), 64'd16);

    // Full-throughput random stream after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tp_in = 0; tp_out = 0;
    for (int cyc = 0; cyc < 102; cyc++) begin
      if (tp_in < 100) begin
        in_valid   = 1'b1;
        ALUControl = 3'($urandom_range(0, 7));
        SrcA       = $urandom;
        SrcB       = ($urandom_range(0, 7) == 0) ? SrcA : $urandom;
        m          = model(ALUControl, SrcA, SrcB);
        tp_r[tp_in] = m[31:0];
        tp_f[tp_in] = m[36:32];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) chk("tp_in_ready", 64'(in_ready), 64'd1);
      if (cyc >= 2) chk("tp_out_valid", 64'(out_valid), 64'd1);
      if (out_valid && tp_out < 100) begin
        chk("tp_result", 64'(Result), 64'(tp_r[tp_out]));
        chk("tp_flags", 64'(flags), 64'(tp_f[tp_out]));
        tp_out++;
      end
      if (in_valid && in_ready) tp_in++;
      tick();
    end
    chk("tp_count_out", 64'(tp_out), 64'd100);
    chk("tp_op_count", 64'(op_count), 64'd100);
    chk("tp_sat_count", 64'(op_count_s), 64'd7);
    chk("tp_drained", 64'(out_valid), 64'd0);

    // Fill both stages under back-pressure, then reset asynchronously
    out_ready = 1'b0;
    in_valid = 1'b1; ALUControl = 3'b000; SrcA = 32'd1; SrcB = 32'd2;
    tick();
    SrcA = 32'd3; SrcB = 32'd4;
    tick();
    in_valid = 1'b0;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_result", 64'(Result), 64'd0);
    chk("async_op_count", 64'(op_count), 64'd0);
    tick();
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      chk("no_stale_beat", 64'(out_valid), 64'd0);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    end
    chk("post_rst_op_count", 64'(op_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
